// File: rtl/stack_pkg.sv
// stack_pkg: shared encodings and constants for the SRP16 stack access sequencer.
`default_nettype none

package stack_pkg;

  localparam int WORD_W  = 16;
  // SP moves by one 16-bit word (two bytes) per access
  localparam int SP_STEP = 2;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PUSH_DEC = 3'd1,
    PUSH_WR  = 3'd2,
    POP_RD   = 3'd3,
    POP_INC  = 3'd4,
    POP_RSP  = 3'd5,
    REJECT   = 3'd6
  } state_t;

endpackage

`default_nettype wire

// File: rtl/stack_depth_cnt.sv
// stack_depth_cnt: up/down occupancy counter with full/empty flags for the stack guard.
`default_nettype none

module stack_depth_cnt #(
  parameter int DEPTH = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic empty
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && !dec) begin
      count <= count + CNT_W'(1);
    end else if (dec && !inc) begin
      count <= count - CNT_W'(1);
    end
  end

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

`default_nettype wire

// File: rtl/stack_seq.sv
// stack_seq: push/pop sequencer driving SP strobes and the memory handshake.
// Optional overflow/underflow guard enabled by defining STACK_GUARD_EN.
`default_nettype none

module stack_seq
  import stack_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_op,
  input  logic [WORD_W-1:0] req_data,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_data,
  input  logic              rsp_ready,
  output logic              done,
  output logic              err,
  output logic              sp_dec,
  output logic              sp_inc,
  output logic              sp_read_abus,
  output logic              mem_req,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  state_t            state;
  state_t            state_nxt;
  logic [WORD_W-1:0] wr_word;
  logic [WORD_W-1:0] rd_word;
  logic              done_q;
  logic              push_blocked;
  logic              pop_blocked;

`ifdef STACK_GUARD_EN
  logic depth_full;
  logic depth_empty;

  stack_depth_cnt #(
    .DEPTH (DEPTH)
  ) u_depth (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (state == PUSH_WR && mem_ack),
    .dec   (state == POP_INC),
    .full  (depth_full),
    .empty (depth_empty)
  );

  assign push_blocked = depth_full;
  assign pop_blocked  = depth_empty;
`else
  assign push_blocked = 1'b0;
  assign pop_blocked  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      wr_word <= '0;
      rd_word <= '0;
      done_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      // done is shown in the IDLE cycle that follows the write acknowledge
      done_q <= (state == PUSH_WR) && mem_ack;
      if (state == IDLE && req_valid) begin
        wr_word <= req_data;
      end
      if (state == POP_RD && mem_ack) begin
        rd_word <= mem_rdata;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    rsp_data     = '0;
    err          = 1'b0;
    sp_dec       = 1'b0;
    sp_inc       = 1'b0;
    sp_read_abus = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_wdata    = '0;

    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_op == OP_PUSH) begin
            state_nxt = push_blocked ? REJECT : PUSH_DEC;
          end else begin
            state_nxt = pop_blocked ? REJECT : POP_RD;
          end
        end
      end
      PUSH_DEC: begin
        sp_dec    = 1'b1;
        state_nxt = PUSH_WR;
      end
      PUSH_WR: begin
        mem_req      = 1'b1;
        mem_we       = 1'b1;
        sp_read_abus = 1'b1;
        mem_wdata    = wr_word;
        if (mem_ack) begin
          state_nxt = IDLE;
        end
      end
      POP_RD: begin
        mem_req      = 1'b1;
        sp_read_abus = 1'b1;
        if (mem_ack) begin
          state_nxt = POP_INC;
        end
      end
      POP_INC: begin
        sp_inc    = 1'b1;
        state_nxt = POP_RSP;
      end
      POP_RSP: begin
        rsp_valid = 1'b1;
        rsp_data  = rd_word;
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      REJECT: begin
`ifdef STACK_GUARD_EN
        err = 1'b1;
`endif
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_stack_seq.sv
// tb_stack_seq: self-checking bench for stack_seq with a memory/SP model and a queue-based stack reference.
`default_nettype none

module tb_stack_seq;
  import stack_pkg::*;

  localparam int DEPTH = 2;
`ifdef STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_op;
  logic [15:0] req_data;
  logic        req_ready;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_ready;
  logic        done;
  logic        err;
  logic        sp_dec;
  logic        sp_inc;
  logic        sp_read_abus;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  stack_seq #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_op       (req_op),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_ready    (rsp_ready),
    .done         (done),
    .err          (err),
    .sp_dec       (sp_dec),
    .sp_inc       (sp_inc),
    .sp_read_abus (sp_read_abus),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Environment model: SP register owner plus word-addressed memory
  logic [15:0] sp_model = 16'h0100;
  logic [15:0] mem [logic [15:0]];
  int          wait_target = 0;
  bit          ack_block = 1'b0;
  int          wait_cnt = 0;
  bit          pending = 1'b0;
  int          n_dec = 0, n_inc = 0, n_acc = 0, n_err = 0;
  logic [15:0] last_wr_addr = 16'h0, last_wr_data = 16'h0, last_rd_addr = 16'h0;

  function automatic logic [40:0] pack_outs();
    return {req_ready, rsp_valid, rsp_data, done, err, sp_dec, sp_inc,
            sp_read_abus, mem_req, mem_we, mem_wdata};
  endfunction

  // Outputs describe what happens at the next rising edge, so the model acts at the falling edge
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 16'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
        pending  = 1'b0;
      end else begin
        vectors++;
        if ($countones({sp_dec, sp_inc, sp_read_abus}) > 1) begin
          miscompares++;
          $display("FAIL strobe_excl: dec=%b inc=%b abus=%b, required at most one high",
                   sp_dec, sp_inc, sp_read_abus);
        end
        if (pending && !mem_req) begin
          miscompares++;
          $display("FAIL mem_req_hold: mem_req=0 before mem_ack, required 1");
        end
        if (mem_req && !ack_block && wait_cnt >= wait_target) begin
          mem_ack = 1'b1;
          if (mem_we) begin
            mem[sp_model] = mem_wdata;
            last_wr_addr  = sp_model;
            last_wr_data  = mem_wdata;
          end else begin
            mem_rdata    = mem.exists(sp_model) ? mem[sp_model] : 16'hDEAD;
            last_rd_addr = sp_model;
          end
          n_acc++;
          wait_cnt = 0;
        end else begin
          mem_ack = 1'b0;
          if (mem_req) wait_cnt++;
          else wait_cnt = 0;
        end
        pending = mem_req && !mem_ack;
        if (sp_dec) begin sp_model = sp_model - 16'(SP_STEP); n_dec++; end
        if (sp_inc) begin sp_model = sp_model + 16'(SP_STEP); n_inc++; end
        if (err) n_err++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_sig(input int which, input int limit, output int cycles, output bit ok);
    ok = 1'b0;
    cycles = 0;
    while (!ok && cycles < limit) begin
      @(posedge clk); #1;
      cycles++;
      case (which)
        0:       ok = done;
        1:       ok = rsp_valid;
        default: ok = req_ready;
      endcase
    end
  endtask

  // Presents one request and returns #1 after the accepting edge
  task automatic issue(input logic op, input logic [15:0] data, output bit ok);
    int c;
    ok = req_ready;
    if (!ok) wait_sig(2, 40, c, ok);
    req_valid = 1'b1;
    req_op    = op;
    req_data  = data;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_op = OP_PUSH; req_data = 16'h0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (pack_outs() !== {1'b1, 40'h0}) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h, required %h", pack_outs(), {1'b1, 40'h0});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (pack_outs() !== {1'b1, 40'h0}) begin
      miscompares++;
      $display("FAIL idle_after_reset: got %h, required %h", pack_outs(), {1'b1, 40'h0});
    end
  endtask

  task automatic test_push();
    bit ok;
    int d0;
    sp_model = 16'h0100; wait_target = 0; d0 = n_dec;
    issue(OP_PUSH, 16'hBEEF, ok);
    vectors++;
    if (!ok || sp_dec !== 1'b1 || mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL push_dec: accepted=%b sp_dec=%b mem_req=%b, required 1 1 0", ok, sp_dec, mem_req);
    end
    @(posedge clk); #1;
    vectors++;
    if ({mem_req, mem_we, sp_read_abus, sp_dec, done} !== 5'b11100 || mem_wdata !== 16'hBEEF
        || sp_model !== 16'h00FE) begin
      miscompares++;
      $display("FAIL push_write: req/we/abus/dec/done=%b wdata=%h sp=%h, required 11100 BEEF 00FE",
               {mem_req, mem_we, sp_read_abus, sp_dec, done}, mem_wdata, sp_model);
    end
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b1 || last_wr_addr !== 16'h00FE || mem[16'h00FE] !== 16'hBEEF || n_dec - d0 != 1) begin
      miscompares++;
      $display("FAIL push_done: done=%b addr=%h data=%h decs=%0d, required 1 00FE BEEF 1",
               done, last_wr_addr, mem[16'h00FE], n_dec - d0);
    end
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL done_pulse: done=%b one cycle later, required 0", done);
    end
  endtask

  task automatic test_pop();
    bit ok;
    int c, i0;
    mem[16'h00FE] = 16'h1234; wait_target = 2; i0 = n_inc;
    issue(OP_POP, 16'h0, ok);
    wait_sig(1, 40, c, ok);
    vectors++;
    if (!ok || c + 1 != 5 || rsp_data !== 16'h1234 || last_rd_addr !== 16'h00FE
        || sp_model !== 16'h0100 || n_inc - i0 != 1) begin
      miscompares++;
      $display("FAIL pop_wait2: seen=%b lat=%0d data=%h addr=%h sp=%h incs=%0d, required 1 5 1234 00FE 0100 1",
               ok, c + 1, rsp_data, last_rd_addr, sp_model, n_inc - i0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    vectors++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL pop_release: rsp_valid=%b req_ready=%b, required 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_rsp_hold();
    bit ok;
    int c, d0, a0;
    logic [15:0] d;
    d = 16'($urandom);
    wait_target = int'($urandom_range(0, 3));
    issue(OP_PUSH, d, ok);
    wait_sig(0, 40, c, ok);
    issue(OP_POP, 16'h0, ok);
    wait_sig(1, 40, c, ok);
    req_valid = 1'b1; req_op = OP_PUSH; req_data = 16'($urandom);
    d0 = n_dec; a0 = n_acc;
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_data !== d || req_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL rsp_hold[%0d]: valid=%b data=%h ready=%b, required 1 %h 0",
                 k, rsp_valid, rsp_data, req_ready, d);
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (n_dec != d0 || n_acc != a0) begin
      miscompares++;
      $display("FAIL hold_no_accept: decs=%0d accesses=%0d during hold, required 0 0", n_dec - d0, n_acc - a0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

`ifdef STACK_GUARD_EN
  task automatic test_guard();
    bit ok;
    int c, d0, a0;
    logic [15:0] a, b, got;
    a = 16'($urandom); b = 16'($urandom); wait_target = 0;
    issue(OP_PUSH, a, ok); wait_sig(0, 40, c, ok);
    issue(OP_PUSH, b, ok); wait_sig(0, 40, c, ok);
    d0 = n_dec; a0 = n_acc;
    issue(OP_PUSH, 16'h5555, ok);
    vectors++;
    if (err !== 1'b1 || sp_dec !== 1'b0 || mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow: err=%b sp_dec=%b mem_req=%b, required 1 0 0", err, sp_dec, mem_req);
    end
    @(posedge clk); #1;
    vectors++;
    if (err !== 1'b0 || req_ready !== 1'b1 || n_dec != d0 || n_acc != a0) begin
      miscompares++;
      $display("FAIL overflow_end: err=%b ready=%b decs=%0d acc=%0d, required 0 1 0 0",
               err, req_ready, n_dec - d0, n_acc - a0);
    end
    for (int k = 0; k < 2; k++) begin
      issue(OP_POP, 16'h0, ok); wait_sig(1, 40, c, ok);
      got = rsp_data;
      vectors++;
      if (got !== ((k == 0) ? b : a)) begin
        miscompares++;
        $display("FAIL guard_pop[%0d]: data=%h, required %h", k, got, (k == 0) ? b : a);
      end
      rsp_ready = 1'b1; @(posedge clk); #1; rsp_ready = 1'b0;
    end
    a0 = n_acc;
    issue(OP_POP, 16'h0, ok);
    vectors++;
    if (err !== 1'b1 || mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL underflow: err=%b mem_req=%b, required 1 0", err, mem_req);
    end
    @(posedge clk); #1;
    vectors++;
    if (n_acc != a0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL underflow_end: accesses=%0d err=%b, required 0 0", n_acc - a0, err);
    end
  endtask
`endif

  task automatic test_mid_reset();
    bit ok;
    int c;
    logic [15:0] y;
    wait_target = 0; ack_block = 1'b1;
    issue(OP_PUSH, 16'hA5A5, ok);
    @(posedge clk); #1;
    vectors++;
    if (mem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL stalled_write: mem_req=%b, required 1", mem_req);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (pack_outs() !== {1'b1, 40'h0}) begin
      miscompares++;
      $display("FAIL async_reset: got %h, required %h", pack_outs(), {1'b1, 40'h0});
    end
    @(posedge clk); #1;
    rst_n = 1'b1; ack_block = 1'b0; sp_model = 16'h0100;
    y = 16'($urandom);
    issue(OP_PUSH, y, ok);
    wait_sig(0, 40, c, ok);
    vectors++;
    if (!ok || c + 1 != 3 || mem[16'h00FE] !== y || sp_model !== 16'h00FE) begin
      miscompares++;
      $display("FAIL push_after_reset: done=%b lat=%0d mem=%h sp=%h, required 1 3 %h 00FE",
               ok, c + 1, mem[16'h00FE], sp_model, y);
    end
  endtask

  task automatic test_random();
    bit ok, exp_rej;
    int c, a0, d0, e0;
    logic op;
    logic [15:0] d, exp_addr, exp_data;
    logic [15:0] q[$];
    logic [15:0] base;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    base = 16'h0200; sp_model = base;
    for (int i = 0; i < 60; i++) begin
      wait_target = int'($urandom_range(0, 3));
      if (q.size() == 0 && !GUARD) op = OP_PUSH;
      else if (q.size() >= 8) op = OP_POP;
      else op = 1'($urandom_range(0, 1));
      d = 16'($urandom);
      exp_rej = GUARD && ((op == OP_PUSH && q.size() == DEPTH) || (op == OP_POP && q.size() == 0));
      a0 = n_acc; d0 = n_dec; e0 = n_err;
      issue(op, d, ok);
      if (exp_rej) begin
        @(posedge clk); #1;
        vectors++;
        if (!ok || n_err - e0 != 1 || n_acc != a0 || n_dec != d0) begin
          miscompares++;
          $display("FAIL rand_reject[%0d]: errs=%0d acc=%0d decs=%0d, required 1 0 0",
                   i, n_err - e0, n_acc - a0, n_dec - d0);
        end
      end else if (op == OP_PUSH) begin
        q.push_back(d);
        exp_addr = 16'(int'(base) - SP_STEP * q.size());
        wait_sig(0, 40, c, ok);
        vectors++;
        if (!ok || c + 1 != 3 + wait_target || last_wr_addr !== exp_addr || last_wr_data !== d
            || n_err != e0) begin
          miscompares++;
          $display("FAIL rand_push[%0d]: lat=%0d addr=%h data=%h errs=%0d, required %0d %h %h 0",
                   i, c + 1, last_wr_addr, last_wr_data, n_err - e0, 3 + wait_target, exp_addr, d);
        end
      end else begin
        exp_addr = 16'(int'(base) - SP_STEP * q.size());
        exp_data = q.pop_back();
        wait_sig(1, 40, c, ok);
        vectors++;
        if (!ok || c + 1 != 3 + wait_target || rsp_data !== exp_data || last_rd_addr !== exp_addr
            || n_err != e0) begin
          miscompares++;
          $display("FAIL rand_pop[%0d]: lat=%0d data=%h addr=%h errs=%0d, required %0d %h %h 0",
                   i, c + 1, rsp_data, last_rd_addr, n_err - e0, 3 + wait_target, exp_data, exp_addr);
        end
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
      end
      vectors++;
      if (sp_model !== 16'(int'(base) - SP_STEP * q.size())) begin
        miscompares++;
        $display("FAIL rand_sp[%0d]: sp=%h, required %h", i, sp_model, 16'(int'(base) - SP_STEP * q.size()));
      end
    end
  endtask

  initial begin
    test_reset();
    test_push();
    test_pop();
    test_rsp_hold();
`ifdef STACK_GUARD_EN
    test_guard();
`endif
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
